fft_reorder: RTL and testbench



---
 rtl/fft_reorder.sv | 87 ++++++++
 tb/tb_fft_reorder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong frame buffer that turns the FFT core's bit-reversed
// output stream into natural order at one sample per clock.
module fft_reorder #(
  parameter int N     = 1024,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im
);
  localparam int L = $clog2(N);
  typedef enum logic {IDLE, READ} state_t;
  logic [2*WIDTH-1:0] mem [0:2*N-1];
  state_t state, state_nx;
  logic [L-1:0] wr_cnt, rd_cnt, rd_cnt_nx;
  logic wr_bank, rd_bank, rd_bank_nx;
  logic [1:0] full, set, clr;
  logic wr_last, rd_last;
  function automatic logic [L-1:0] bitrev(input logic [L-1:0] a);
    for (int i = 0; i < L; i++) bitrev[i] = a[L-1-i];
  endfunction
  assign wr_last = enable_in && &wr_cnt;
  assign rd_last = state == READ && &rd_cnt;
  assign set = wr_last ? 2'b01 << wr_bank : 2'b00;
  assign clr = rd_last ? 2'b01 << rd_bank : 2'b00;
  always_ff @(posedge clk) begin
    if (enable_in) mem[{wr_bank, bitrev(wr_cnt)}] <= {in_re, in_im};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      full    <= 2'b00;
    end else begin
      full <= set | (full & ~clr);
      if (enable_in) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_last) wr_bank <= ~wr_bank;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_cnt  <= rd_cnt_nx;
      rd_bank <= rd_bank_nx;
    end
  end
  // With both banks full the older one is the bank the writer is about to reuse.
  always_comb begin
    state_nx   = state;
    rd_cnt_nx  = rd_cnt;
    rd_bank_nx = rd_bank;
    if (state == IDLE) begin
      if (|full) begin
        state_nx   = READ;
        rd_cnt_nx  = '0;
        rd_bank_nx = &full ? wr_bank : full[1];
      end
    end else begin
      rd_cnt_nx = rd_cnt + 1'b1;
      if (rd_last) begin
        rd_bank_nx = ~rd_bank;
        state_nx   = full[~rd_bank] ? READ : IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_out <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
    end else begin
      enable_out <= state == READ;
      if (state == READ) {out_re, out_im} <= mem[{rd_bank, rd_cnt}];
    end
  end
endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: scoreboard bench for fft_reorder at N=16 and at the default N=1024.
module tb_fft_reorder;
  localparam int W = 8;
  logic clk = 0;
  logic rst_n;
  logic en, en_o, en2, en_o2;
  logic [W-1:0] re, im, ore, oim, re2, im2, ore2, oim2;
  typedef struct {int re; int im;} exp_t;
  exp_t sb[$], sb2[$];
  int bursts[$], starts[$];
  int run = 0, cyc = 0, outs2 = 0, n_chk = 0, n_err = 0;
  int seq[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int le;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  fft_reorder #(.N(16), .WIDTH(W)) d16 (
    .clk(clk), .rst_n(rst_n), .enable_in(en), .in_re(re), .in_im(im),
    .enable_out(en_o), .out_re(ore), .out_im(oim));
  fft_reorder d1k (
    .clk(clk), .rst_n(rst_n), .enable_in(en2), .in_re(re2), .in_im(im2),
    .enable_out(en_o2), .out_re(ore2), .out_im(oim2));
  task automatic check(string tag, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (en_o) begin
      if (run == 0) starts.push_back(cyc);
      run++;
      if (sb.size() == 0) check("spurious_out", int'(en_o), 0);
      else begin
        e = sb.pop_front();
        check("out_re", int'($signed(ore)), e.re);
        check("out_im", int'($signed(oim)), e.im);
      end
    end else if (run != 0) begin
      bursts.push_back(run);
      run = 0;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (en_o2) begin
      outs2++;
      if (sb2.size() == 0) check("spurious_out_1k", int'(en_o2), 0);
      else begin
        e = sb2.pop_front();
        check($sformatf("re1k[%0d]", outs2 - 1), int'($signed(ore2)), e.re);
        check($sformatf("im1k[%0d]", outs2 - 1), int'($signed(oim2)), e.im);
      end
    end
  end
  task automatic send(int base, int cnt, bit gap, output int last_edge);
    for (int c = 0; c < cnt; c++) begin
      @(negedge clk);
      en = 1;
      re = W'(base + c);
      im = W'(-(base + c));
      last_edge = cyc + 1;
      if (gap) begin
        @(negedge clk);
        en = 0;
      end
    end
    if (cnt == 16)
      for (int k = 0; k < 16; k++) sb.push_back('{base + seq[k], -(base + seq[k])});
  endtask
  task automatic idle();
    @(negedge clk);
    en = 0;
  endtask
  task automatic wait_bursts(string tag, int n);
    int t = 0;
    while (bursts.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, bursts.size(), n);
  endtask
  task automatic frame_result(string tag, int len, int last_edge);
    wait_bursts({tag, "_bursts"}, 1);
    check({tag, "_len"}, bursts.size() > 0 ? bursts[0] : -1, len);
    check({tag, "_latency"}, starts.size() > 0 ? starts[0] - last_edge : -1, 2);
    check({tag, "_drained"}, sb.size(), 0);
    bursts.delete();
    starts.delete();
  endtask
  initial begin
    int fe, t;
    rst_n = 1; en = 0; re = 0; im = 0; en2 = 0; re2 = 0; im2 = 0;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    check("rst_en", int'(en_o), 0);
    check("rst_re", int'(ore), 0);
    check("rst_im", int'(oim), 0);
    #1 rst_n = 1;
    send(0, 16, 0, le);
    idle();
    frame_result("ramp", 16, le);
    send(0, 16, 0, fe);
    for (int f = 1; f < 4; f++) send(16 * f, 16, 0, le);
    idle();
    frame_result("b2b", 64, fe);
    send(0, 16, 1, le);
    idle();
    frame_result("gapped", 16, le);
    send(0, 10, 0, le);
    idle();
    #2 rst_n = 0;
    #1;
    check("midframe_rst_en", int'(en_o), 0);
    check("midframe_rst_re", int'(ore), 0);
    check("midframe_rst_im", int'(oim), 0);
    #1 rst_n = 1;
    send(0, 16, 0, le);
    idle();
    frame_result("after_frame_rst", 16, le);
    send(0, 16, 0, le);
    idle();
    repeat (6) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midread_rst_en", int'(en_o), 0);
    check("midread_rst_re", int'(ore), 0);
    sb.delete();
    #1 rst_n = 1;
    repeat (40) @(negedge clk);
    check("midread_bursts", bursts.size(), 1);
    check("midread_len", bursts.size() > 0 ? bursts[0] : -1, 5);
    check("midread_hold_re", int'(ore), 0);
    bursts.delete();
    starts.delete();
    send(32, 16, 0, le);
    idle();
    frame_result("after_read_rst", 16, le);
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      en2 = 1;
      re2 = c == 1 ? W'(127) : W'(0);
      im2 = 0;
    end
    for (int k = 0; k < 1024; k++) sb2.push_back('{k == 512 ? 127 : 0, 0});
    @(negedge clk);
    en2 = 0;
    t = 0;
    while (outs2 < 1024 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("impulse_count", outs2, 1024);
    check("impulse_drained", sb2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
